// File: rtl/hb_rd_packer.sv
// Packs 16-bit elastic-buffer read words into 32-bit beats with a burst-bounded
// last flag and hands them out through a small first-word-fall-through FIFO.
module hb_rd_packer #(
  parameter int C_LEN_WIDTH  = 8,
  parameter int C_FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   rd_start,
  input  logic [C_LEN_WIDTH-1:0] rd_len,
  output logic                   rd_busy,
  output logic                   rd_done,
  input  logic [15:0]            din,
  input  logic                   din_vld,
  output logic [31:0]            m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   ovf,
  output logic                   stray
);

  localparam int AW = $clog2(C_FIFO_DEPTH);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                 state;
  logic [C_LEN_WIDTH-1:0] remaining;
  logic                   half;
  logic [15:0]            low_word;

  logic [32:0]            mem [C_FIFO_DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [32:0]            head;

  logic                   last_word;
  logic                   push;
  logic                   push_last;
  logic [31:0]            push_data;
  logic                   empty;
  logic                   full;
  logic                   pop;
  logic                   wr_en;

  // Handshake: a beat transfers on every edge where m_tvalid && m_tready; the
  // head holds stable otherwise. The din side has no backpressure at all.
  always_comb begin
    last_word = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    push_data = '0;
    empty     = 1'b0;
    full      = 1'b0;
    pop       = 1'b0;
    wr_en     = 1'b0;

    last_word = (remaining == C_LEN_WIDTH'(1));
    push      = (state == COLLECT) && din_vld && (half || last_word);
    push_last = last_word;
    push_data = half ? {din, low_word} : {16'h0000, din};

    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop   = !empty && m_tready;
    // Full is judged before the same-cycle pop, so a pop frees room for a push.
    wr_en = push && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= IDLE;
      remaining <= '0;
      half      <= 1'b0;
      low_word  <= '0;
      rd_busy   <= 1'b0;
      rd_done   <= 1'b0;
      stray     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      stray   <= 1'b0;
      if (push && full && !pop) begin
        ovf <= 1'b1;
      end
      case (state)
        IDLE: begin
          stray <= din_vld;
          if (rd_start && (rd_len != '0)) begin
            remaining <= rd_len;
            half      <= 1'b0;
            rd_busy   <= 1'b1;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (din_vld) begin
            if (remaining != '0) begin
              remaining <= remaining - C_LEN_WIDTH'(1);
            end
            if (push) begin
              half <= 1'b0;
              // A dropped final beat still completes the burst.
              if (push_last) begin
                rd_busy <= 1'b0;
                rd_done <= 1'b1;
                state   <= IDLE;
              end
            end else begin
              low_word <= din;
              half     <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!srst && wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {push_last, push_data};
    end
  end

  // Head is masked while empty so stale storage never shows on the outputs.
  assign head     = mem[rd_ptr[AW-1:0]];
  assign m_tvalid = !empty;
  assign m_tdata  = m_tvalid ? head[31:0] : 32'h0000_0000;
  assign m_tlast  = m_tvalid && head[32];

endmodule

// File: tb/tb_hb_rd_packer.sv
// Directed and randomized checks of hb_rd_packer against a word-list / beat-queue
// reference model of the packing and stream FIFO.
module tb_hb_rd_packer;

  localparam int LW    = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          srst;
  logic          rd_start;
  logic [LW-1:0] rd_len;
  logic          rd_busy;
  logic          rd_done;
  logic [15:0]   din;
  logic          din_vld;
  logic [31:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          ovf;
  logic          stray;

  int checks = 0;
  int errors = 0;
  int pops_seen = 0;

  // reference model state
  bit          mdl_busy;
  int          mdl_left;
  logic [15:0] mdl_words[$];
  logic [32:0] exp_q[$];
  bit          mdl_ovf;
  bit          mdl_done;
  bit          mdl_stray;

  hb_rd_packer #(.C_LEN_WIDTH(LW), .C_FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .srst     (srst),
    .rd_start (rd_start),
    .rd_len   (rd_len),
    .rd_busy  (rd_busy),
    .rd_done  (rd_done),
    .din      (din),
    .din_vld  (din_vld),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .ovf      (ovf),
    .stray    (stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [32:0] hd;
    bit          v;
    v  = (exp_q.size() != 0);
    hd = v ? exp_q[0] : 33'h0;
    check($sformatf("flags@%0t", $time),
          {30'h0, rd_busy, rd_done, stray, ovf, m_tvalid, m_tlast},
          {30'h0, mdl_busy, mdl_done, mdl_stray, mdl_ovf, v, hd[32]});
    check($sformatf("tdata@%0t", $time), {4'h0, m_tdata}, {4'h0, hd[31:0]});
  endtask

  // Advance the model by one clock using the inputs currently applied, then
  // let the DUT take the edge and compare just after it.
  task automatic cycle();
    logic [32:0] beat;
    bit          do_push;
    bit          pop;
    bit          full;
    beat    = '0;
    do_push = 1'b0;
    if (m_tvalid && m_tready) pops_seen++;
    if (srst) begin
      mdl_busy = 1'b0;
      mdl_left = 0;
      mdl_words.delete();
      exp_q.delete();
      mdl_ovf   = 1'b0;
      mdl_done  = 1'b0;
      mdl_stray = 1'b0;
    end else begin
      pop       = (exp_q.size() != 0) && m_tready;
      full      = (exp_q.size() == DEPTH);
      mdl_done  = 1'b0;
      mdl_stray = 1'b0;
      if (!mdl_busy) begin
        mdl_stray = din_vld;
        if (rd_start && rd_len != 0) begin
          mdl_busy = 1'b1;
          mdl_left = int'(rd_len);
          mdl_words.delete();
        end
      end else if (din_vld) begin
        mdl_words.push_back(din);
        mdl_left--;
        if (mdl_words.size() == 2 || mdl_left == 0) begin
          if (mdl_words.size() == 2) beat[31:0] = {mdl_words[1], mdl_words[0]};
          else                       beat[31:0] = {16'h0000, mdl_words[0]};
          beat[32] = (mdl_left == 0);
          do_push  = 1'b1;
          mdl_words.delete();
          if (mdl_left == 0) begin
            mdl_busy = 1'b0;
            mdl_done = 1'b1;
          end
        end
      end
      if (pop) void'(exp_q.pop_front());
      if (do_push) begin
        if (full && !pop) mdl_ovf = 1'b1;
        else              exp_q.push_back(beat);
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic step(input bit st, input logic [LW-1:0] len, input bit vld, input logic [15:0] d);
    rd_start = st;
    rd_len   = len;
    din_vld  = vld;
    din      = d;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 16'h0);
  endtask

  initial begin
    int  len;
    int  budget;
    srst     = 1'b1;
    rd_start = 1'b0;
    rd_len   = '0;
    din      = '0;
    din_vld  = 1'b0;
    m_tready = 1'b1;

    // reset held for two cycles
    cycle();
    cycle();
    check("reset_tdata", {4'h0, m_tdata}, 36'h0);
    check("reset_flags", {30'h0, rd_busy, rd_done, stray, ovf, m_tvalid, m_tlast}, 36'h0);
    srst = 1'b0;
    idle(3);

    // four words back to back
    step(1'b1, 8'd4, 1'b0, 16'h0);
    check("busy_after_start", {35'h0, rd_busy}, 36'h1);
    step(1'b0, '0, 1'b1, 16'h1111);
    step(1'b0, '0, 1'b1, 16'h2222);
    check("len4_beat0", {3'h0, m_tvalid, m_tlast, m_tdata}, {3'h0, 1'b1, 1'b0, 32'h2222_1111});
    step(1'b0, '0, 1'b1, 16'h3333);
    step(1'b0, '0, 1'b1, 16'h4444);
    check("len4_beat1", {3'h0, m_tvalid, m_tlast, m_tdata}, {3'h0, 1'b1, 1'b1, 32'h4444_3333});
    check("len4_done", {34'h0, rd_done, rd_busy}, 36'h2);
    idle(3);

    // odd length with gaps
    step(1'b1, 8'd3, 1'b0, 16'h0);
    step(1'b0, '0, 1'b1, 16'hA001);
    idle(2);
    step(1'b0, '0, 1'b1, 16'hA002);
    idle(1);
    step(1'b0, '0, 1'b1, 16'hA003);
    check("len3_tail", {3'h0, m_tvalid, m_tlast, m_tdata}, {3'h0, 1'b1, 1'b1, 32'h0000_A003});
    idle(3);

    // overflow with a stalled consumer
    m_tready = 1'b0;
    step(1'b1, 8'd12, 1'b0, 16'h0);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 16'hB000 + 16'(i));
    check("ovf_set", {35'h0, ovf}, 36'h1);
    idle(2);
    pops_seen = 0;
    m_tready  = 1'b1;
    idle(8);
    check("ovf_drain_count", 36'(pops_seen), 36'd4);

    // stray word in idle, then rd_start ignored while collecting
    step(1'b0, '0, 1'b1, 16'hBEEF);
    check("stray_pulse", {34'h0, stray, m_tvalid}, 36'h2);
    step(1'b1, 8'd2, 1'b0, 16'h0);
    step(1'b1, 8'd6, 1'b1, 16'hC001);
    step(1'b0, '0, 1'b1, 16'hC002);
    check("restart_ignored", {34'h0, rd_done, m_tlast}, 36'h3);
    step(1'b0, '0, 1'b1, 16'hC003);
    check("late_word_stray", {35'h0, stray}, 36'h1);
    idle(3);

    // reset in the middle of a burst
    m_tready = 1'b0;
    step(1'b1, 8'd8, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 16'hD000 + 16'(i));
    srst = 1'b1;
    step(1'b0, '0, 1'b0, 16'h0);
    check("midreset_zero", {rd_busy, rd_done, stray, ovf, m_tvalid, m_tlast, m_tdata[29:0]}, 36'h0);
    srst     = 1'b0;
    m_tready = 1'b1;
    step(1'b1, 8'd2, 1'b0, 16'h0);
    step(1'b0, '0, 1'b1, 16'hE001);
    step(1'b0, '0, 1'b1, 16'hE002);
    check("post_reset_burst", {3'h0, m_tvalid, m_tlast, m_tdata}, {3'h0, 1'b1, 1'b1, 32'hE002_E001});
    idle(3);

    // randomized bursts
    for (int b = 0; b < 60; b++) begin
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
      m_tready = ($urandom_range(0, 9) < 7);
      step(1'b1, LW'(len), ($urandom_range(0, 7) == 0), 16'($urandom));
      budget = 0;
      while (mdl_busy && budget < 400) begin
        m_tready = ($urandom_range(0, 9) < 7);
        step(($urandom_range(0, 15) == 0), LW'($urandom_range(0, 30)),
             ($urandom_range(0, 9) < 6), 16'($urandom));
        budget++;
      end
      check("burst_budget", {35'h0, (budget < 400)}, 36'h1);
      m_tready = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < int'($urandom_range(0, 4)); k++)
        step(1'b0, '0, ($urandom_range(0, 5) == 0), 16'($urandom));
    end
    m_tready = 1'b1;
    idle(DEPTH + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
